pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register for the 32-bit MIPS pipeline. It generalises the fixed EX/MEM latch in three ways: configurable payload and control widths, a valid/ready handshake with an optional 2-entry skid buffer for back-pressure, and a flush that turns held beats into bubbles. It sits between any two pipeline stages (ID/EX, EX/MEM, MEM/WB). It also keeps a saturating count of squashed beats for performance monitoring.

## Interface
- DATA_W, default 102: payload width (PC+4+off, result, operand B, equal, write register).
- CTRL_W, default 6: control field width (MEM 4 + WB 2). This field is the part zeroed on flush.
- SKID, default 1: 1 selects a 2-entry skid buffer with registered in_ready; 0 selects a single register with combinational stall.
- CNT_W, default 16: width of the flush counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control
- flush  in  1  exception/branch squash
- out_valid  out  1  output beat present
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  registered payload
- out_ctrl  out  CTRL_W  registered control
- flush_cnt  out  CNT_W  saturating count of squashed beats

## Operation
- A beat is accepted when in_valid && in_ready. A beat is delivered when out_valid && out_ready.
- State is a main entry (drives the outputs) plus, when SKID=1, one skid entry. Each entry holds valid, data and ctrl.
- SKID=1:
  - in_ready = !skid_valid, driven straight from a flop.
  - Accepted beat with main empty, or main delivering this cycle → goes to main.
  - Accepted beat with main holding and not delivering → goes to skid.
  - Main delivering while skid is valid → skid moves to main, skid empties. A simultaneous accept is impossible because in_ready is 0.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - On accept, main loads. On delivery with no accept, main_valid clears.
  - Holding: main keeps its data while out_valid && !out_ready.
- Flush: every valid beat that is stored or kept at the clock edge has ctrl written to 0. This covers the incoming beat, the held main entry, and the skid entry. Data and valid are unchanged.
  - The result is a bubble: data still flows, but there are no memory or register-file side effects.
  - A beat delivered in the flush cycle leaves with its original ctrl.
- flush_cnt increments by the number of valid beats squashed in the cycle (0–2; 3 is impossible). It saturates at 2^CNT_W−1.
- Invalid entries hold their last data. Their ctrl is don't-care, but out_ctrl is forced to 0 whenever out_valid=0.

## Timing
- Latency is 1 cycle from accept to out_valid when main is empty or draining.
- Throughput is 1 beat/cycle with out_ready held high in both modes.
- Reset values:
  - out_valid=0, out_data=0, out_ctrl=0, flush_cnt=0.
  - Skid entry empty, so in_ready=1 once reset deasserts (in_ready also reads 1 during reset in SKID=1).
- Reset asserted mid-operation drops all held beats immediately, without waiting for a clock edge.
- In SKID=1, in_ready falls one cycle after the skid entry fills and rises one cycle after it drains.
- Simultaneous flush and back-pressure: held beats are squashed in place and stay valid until delivered.

## Structure
- Shared package pipe_pkg holds:
  - MEM_W=4, WB_W=2, CTRL_W=MEM_W+WB_W
  - the EX/MEM payload field offsets
  - a function that returns the bubble (zero) control word
- Single module, with no sub-module.
- A generate on SKID selects the ready logic and the skid entry.
- The saturating counter stays inline.

## Test plan
- Reset mid-stream: main and skid both full, reset pulses between clock edges → out_valid=0 and flush_cnt=0 at once; in_ready=1 after reset deasserts.
- Streaming, SKID=1, out_ready=1: beats D0..D3 with ctrl=6'h2D → outputs appear one cycle later, in order, unchanged.
- Back-pressure, SKID=1: out_ready=0 while D0 and D1 arrive → D0 held on the outputs, D1 in skid, in_ready=0 on the next cycle. Then out_ready=1 → D0, then D1, and in_ready=1 one cycle after the skid drains.
- Flush with both entries valid and out_ready=0 → both ctrl become 0, data unchanged, flush_cnt increments by 2.
- Flush on an accept cycle, main empty: in_ctrl=6'h3F → out_ctrl=0 next cycle, out_data matches in_data, flush_cnt+1.
- SKID=0 with CNT_W=2: four squashed beats → flush_cnt saturates at 3. Also check in_ready equals out_ready combinationally while main is full.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control field split, EX/MEM payload layout and
// the bubble control word used when a beat is squashed.
package pipe_pkg;
   localparam int MEM_W  = 4;
   localparam int WB_W   = 2;
   localparam int CTRL_W = MEM_W + WB_W;

   // EX/MEM payload layout, LSB first: wreg, equal, operand B, result, PC+4+off
   localparam int WREG_W    = 5;
   localparam int WREG_LSB  = 0;
   localparam int EQ_LSB    = WREG_LSB + WREG_W;
   localparam int OPB_LSB   = EQ_LSB + 1;
   localparam int RES_LSB   = OPB_LSB + 32;
   localparam int PCOFF_LSB = RES_LSB + 32;
   localparam int EXMEM_W   = PCOFF_LSB + 32;

   function automatic logic [CTRL_W-1:0] bubble_ctrl();
      return '0;
   endfunction
endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage latch with valid/ready handshake, optional 2-entry
// skid buffer, flush-to-bubble and a saturating squashed-beat counter.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = EXMEM_W,
   parameter int CTRL_W = pipe_pkg::CTRL_W,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [CTRL_W-1:0] BUBBLE = CTRL_W'(bubble_ctrl());

   logic              main_v_q, main_v_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic              skid_v_d;
   logic              accept, deliver;
   logic [1:0]        sq_cnt;
   logic [CNT_W:0]    cnt_sum;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   assign accept  = in_valid && in_ready;
   assign deliver = main_v_q && out_ready;

   generate
      if (SKID != 0) begin : g_skid
         logic              skid_v_q, skid_v_n;
         logic [DATA_W-1:0] skid_data_q, skid_data_d;
         logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

         assign in_ready = !skid_v_q;
         assign skid_v_d = skid_v_n;

         always_comb begin
            main_v_d    = main_v_q;
            main_data_d = main_data_q;
            main_ctrl_d = main_ctrl_q;
            skid_v_n    = skid_v_q;
            skid_data_d = skid_data_q;
            skid_ctrl_d = skid_ctrl_q;
            if (deliver && skid_v_q) begin
               main_v_d    = 1'b1;
               main_data_d = skid_data_q;
               main_ctrl_d = skid_ctrl_q;
               skid_v_n    = 1'b0;
            end else if (accept && (!main_v_q || deliver)) begin
               main_v_d    = 1'b1;
               main_data_d = in_data;
               main_ctrl_d = in_ctrl;
            end else if (accept) begin
               skid_v_n    = 1'b1;
               skid_data_d = in_data;
               skid_ctrl_d = in_ctrl;
            end else if (deliver) begin
               main_v_d    = 1'b0;
            end
            // Squash whatever survives the edge; the departing beat is unaffected
            if (flush) begin
               if (main_v_d) main_ctrl_d = BUBBLE;
               if (skid_v_n) skid_ctrl_d = BUBBLE;
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               skid_v_q    <= 1'b0;
               skid_data_q <= '0;
               skid_ctrl_q <= '0;
            end else begin
               skid_v_q    <= skid_v_n;
               skid_data_q <= skid_data_d;
               skid_ctrl_q <= skid_ctrl_d;
            end
         end
      end else begin : g_noskid
         assign in_ready = !main_v_q || out_ready;
         assign skid_v_d = 1'b0;

         always_comb begin
            main_v_d    = main_v_q;
            main_data_d = main_data_q;
            main_ctrl_d = main_ctrl_q;
            if (accept) begin
               main_v_d    = 1'b1;
               main_data_d = in_data;
               main_ctrl_d = in_ctrl;
            end else if (deliver) begin
               main_v_d    = 1'b0;
            end
            if (flush && main_v_d) main_ctrl_d = BUBBLE;
         end
      end
   endgenerate

   assign sq_cnt  = flush ? ({1'b0, main_v_d} + {1'b0, skid_v_d}) : 2'd0;
   assign cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(sq_cnt);
   assign cnt_d   = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_v_q    <= 1'b0;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         cnt_q       <= '0;
      end else begin
         main_v_q    <= main_v_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = main_v_q;
   assign out_data  = main_data_q;
   assign out_ctrl  = main_v_q ? main_ctrl_q : BUBBLE;
   assign flush_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid (A) and non-skid 2-bit-counter (B) instances,
// directed vectors plus random traffic against a queue-based reference.
module tb_pipe_stage_reg;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        a_vi, a_rdy, a_fl, a_ov, a_ordy;
   logic [31:0] a_d, a_od;
   logic [5:0]  a_c, a_oc;
   logic [15:0] a_cnt;

   logic        b_vi, b_rdy, b_fl, b_ov, b_ordy;
   logic [31:0] b_d, b_od;
   logic [5:0]  b_c, b_oc;
   logic [1:0]  b_cnt;

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(6), .SKID(1), .CNT_W(16)) dut_a (
      .clk(clk), .reset(reset), .in_valid(a_vi), .in_ready(a_rdy), .in_data(a_d),
      .in_ctrl(a_c), .flush(a_fl), .out_valid(a_ov), .out_ready(a_ordy),
      .out_data(a_od), .out_ctrl(a_oc), .flush_cnt(a_cnt));

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(6), .SKID(0), .CNT_W(2)) dut_b (
      .clk(clk), .reset(reset), .in_valid(b_vi), .in_ready(b_rdy), .in_data(b_d),
      .in_ctrl(b_c), .flush(b_fl), .out_valid(b_ov), .out_ready(b_ordy),
      .out_data(b_od), .out_ctrl(b_oc), .flush_cnt(b_cnt));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: a stage is just a FIFO of beats (capacity 2 with skid, 1 without)
   typedef struct { logic [31:0] d; logic [5:0] c; } beat_t;
   beat_t qa[$];
   beat_t qb[$];
   int    ca, cb;

   function automatic logic model_rdy(input int sel, input logic ordy);
      if (sel == 0) return qa.size() < 2;
      return (qb.size() == 0) || ordy;
   endfunction

   task automatic model_step(input int sel, input logic vi, input logic [31:0] d,
                             input logic [5:0] c, input logic fl, input logic ordy);
      beat_t q[$];
      beat_t nb;
      logic  rdy;
      int    cnt, maxc;
      rdy  = model_rdy(sel, ordy);
      q    = (sel == 0) ? qa : qb;
      cnt  = (sel == 0) ? ca : cb;
      maxc = (sel == 0) ? 65535 : 3;
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (vi && rdy) begin
         nb.d = d;
         nb.c = c;
         q.push_back(nb);
      end
      if (fl) begin
         foreach (q[i]) q[i].c = 6'h00;
         cnt = cnt + q.size();
         if (cnt > maxc) cnt = maxc;
      end
      if (sel == 0) begin qa = q; ca = cnt; end
      else          begin qb = q; cb = cnt; end
   endtask

   task automatic idle_inputs();
      a_vi = 0; a_d = '0; a_c = '0; a_fl = 0; a_ordy = 0;
      b_vi = 0; b_d = '0; b_c = '0; b_fl = 0; b_ordy = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      qa.delete(); qb.delete(); ca = 0; cb = 0;
   endtask

   typedef struct {
      logic vi; logic [31:0] d; logic [5:0] c; logic fl; logic ordy;
      logic rdy; logic ov; logic [31:0] od; logic [5:0] oc; logic [15:0] cnt;
   } vec_t;
   vec_t vt[20];

   initial begin
      vt[0]  = '{1'b1, 32'hD000_0000, 6'h2D, 1'b0, 1'b1, 1'b1, 1'b1, 32'hD000_0000, 6'h2D, 16'd0};
      vt[1]  = '{1'b1, 32'hD000_0001, 6'h2D, 1'b0, 1'b1, 1'b1, 1'b1, 32'hD000_0001, 6'h2D, 16'd0};
      vt[2]  = '{1'b1, 32'hD000_0002, 6'h2D, 1'b0, 1'b1, 1'b1, 1'b1, 32'hD000_0002, 6'h2D, 16'd0};
      vt[3]  = '{1'b1, 32'hD000_0003, 6'h2D, 1'b0, 1'b1, 1'b1, 1'b1, 32'hD000_0003, 6'h2D, 16'd0};
      vt[4]  = '{1'b0, 32'h0,         6'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         6'h00, 16'd0};
      vt[5]  = '{1'b1, 32'hB000_0000, 6'h15, 1'b0, 1'b0, 1'b1, 1'b1, 32'hB000_0000, 6'h15, 16'd0};
      vt[6]  = '{1'b1, 32'hB000_0001, 6'h2A, 1'b0, 1'b0, 1'b1, 1'b1, 32'hB000_0000, 6'h15, 16'd0};
      vt[7]  = '{1'b0, 32'h0,         6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'hB000_0000, 6'h15, 16'd0};
      vt[8]  = '{1'b0, 32'h0,         6'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'hB000_0001, 6'h2A, 16'd0};
      vt[9]  = '{1'b0, 32'h0,         6'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         6'h00, 16'd0};
      vt[10] = '{1'b1, 32'hF000_0000, 6'h3F, 1'b0, 1'b0, 1'b1, 1'b1, 32'hF000_0000, 6'h3F, 16'd0};
      vt[11] = '{1'b1, 32'hF000_0001, 6'h11, 1'b0, 1'b0, 1'b1, 1'b1, 32'hF000_0000, 6'h3F, 16'd0};
      vt[12] = '{1'b0, 32'h0,         6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'hF000_0000, 6'h00, 16'd2};
      vt[13] = '{1'b0, 32'h0,         6'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'hF000_0001, 6'h00, 16'd2};
      vt[14] = '{1'b0, 32'h0,         6'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         6'h00, 16'd2};
      vt[15] = '{1'b1, 32'hE000_0000, 6'h3F, 1'b1, 1'b1, 1'b1, 1'b1, 32'hE000_0000, 6'h00, 16'd3};
      vt[16] = '{1'b0, 32'h0,         6'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         6'h00, 16'd3};
      vt[17] = '{1'b1, 32'hA000_0000, 6'h21, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA000_0000, 6'h21, 16'd3};
      vt[18] = '{1'b1, 32'hA000_0001, 6'h22, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA000_0001, 6'h00, 16'd4};
      vt[19] = '{1'b0, 32'h0,         6'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         6'h00, 16'd4};

      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst a out_valid", a_ov, 0);
      chk("rst a out_data", a_od, 0);
      chk("rst a out_ctrl", a_oc, 0);
      chk("rst a flush_cnt", a_cnt, 0);
      chk("rst a in_ready", a_rdy, 1);
      chk("rst b out_valid", b_ov, 0);
      chk("rst b flush_cnt", b_cnt, 0);
      reset = 1'b0;

      // Directed vectors on the skid instance
      for (int i = 0; i < 20; i++) begin
         a_vi = vt[i].vi; a_d = vt[i].d; a_c = vt[i].c; a_fl = vt[i].fl; a_ordy = vt[i].ordy;
         @(negedge clk);
         chk($sformatf("vec%0d in_ready", i), a_rdy, vt[i].rdy);
         @(posedge clk); #1;
         chk($sformatf("vec%0d out_valid", i), a_ov, vt[i].ov);
         if (vt[i].ov) chk($sformatf("vec%0d out_data", i), a_od, vt[i].od);
         chk($sformatf("vec%0d out_ctrl", i), a_oc, vt[i].oc);
         chk($sformatf("vec%0d flush_cnt", i), a_cnt, vt[i].cnt);
      end

      // Reset pulse between edges with both entries full
      a_vi = 1; a_d = 32'h1111_0000; a_c = 6'h0C; a_fl = 0; a_ordy = 0;
      @(posedge clk); #1;
      a_d = 32'h1111_0001; a_c = 6'h0D;
      @(posedge clk); #1;
      a_vi = 0;
      chk("midrst pre out_valid", a_ov, 1);
      chk("midrst pre in_ready", a_rdy, 0);
      #1 reset = 1'b1;
      #1;
      chk("midrst out_valid", a_ov, 0);
      chk("midrst flush_cnt", a_cnt, 0);
      chk("midrst out_ctrl", a_oc, 0);
      chk("midrst out_data", a_od, 0);
      chk("midrst in_ready during", a_rdy, 1);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      chk("midrst after out_valid", a_ov, 0);
      chk("midrst after in_ready", a_rdy, 1);

      // Random traffic on both instances against the FIFO reference
      idle_inputs();
      do_reset();
      for (int n = 0; n < 400; n++) begin
         a_vi = ($urandom_range(0, 3) != 0); a_d = $urandom; a_c = 6'($urandom_range(0, 63));
         a_fl = ($urandom_range(0, 7) == 0); a_ordy = ($urandom_range(0, 2) != 0);
         b_vi = ($urandom_range(0, 3) != 0); b_d = $urandom; b_c = 6'($urandom_range(0, 63));
         b_fl = ($urandom_range(0, 7) == 0); b_ordy = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         chk("rnd a in_ready", a_rdy, model_rdy(0, a_ordy));
         chk("rnd b in_ready", b_rdy, model_rdy(1, b_ordy));
         model_step(0, a_vi, a_d, a_c, a_fl, a_ordy);
         model_step(1, b_vi, b_d, b_c, b_fl, b_ordy);
         @(posedge clk); #1;
         chk("rnd a out_valid", a_ov, qa.size() > 0);
         chk("rnd b out_valid", b_ov, qb.size() > 0);
         if (qa.size() > 0) begin
            chk("rnd a out_data", a_od, qa[0].d);
            chk("rnd a out_ctrl", a_oc, qa[0].c);
         end else chk("rnd a out_ctrl idle", a_oc, 0);
         if (qb.size() > 0) begin
            chk("rnd b out_data", b_od, qb[0].d);
            chk("rnd b out_ctrl", b_oc, qb[0].c);
         end else chk("rnd b out_ctrl idle", b_oc, 0);
         chk("rnd a flush_cnt", a_cnt, ca);
         chk("rnd b flush_cnt", b_cnt, cb);
      end

      // Non-skid: counter saturation and combinational ready
      idle_inputs();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         b_vi = 1; b_d = 32'hC000_0000 + k; b_c = 6'h3F; b_fl = 1; b_ordy = 1;
         @(posedge clk); #1;
         chk($sformatf("sat%0d out_ctrl", k), b_oc, 0);
         chk($sformatf("sat%0d out_data", k), b_od, 32'hC000_0000 + k);
         chk($sformatf("sat%0d flush_cnt", k), b_cnt, (k < 3) ? k + 1 : 3);
      end
      b_vi = 0; b_fl = 0; b_ordy = 0;
      #1;
      chk("comb in_ready low", b_rdy, 0);
      @(posedge clk); #1;
      chk("hold out_valid", b_ov, 1);
      chk("hold out_data", b_od, 32'hC000_0003);
      b_ordy = 1;
      #1;
      chk("comb in_ready high", b_rdy, 1);
      b_ordy = 0;
      #1;
      chk("comb in_ready low again", b_rdy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
